// File: rtl/text_buffer_pkg.sv
// text_buffer_pkg: shared definitions for the text frame buffer.
//   - default screen geometry (80x60 cells of 8x8 px)
//   - control codes understood by the write port
//   - FSM state encodings (legacy-style localparam constants)
//   - address helpers shared by the read and write paths
// `FONT_WIDTH defaults to 8 when the build does not supply it (must be >= 7).
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

package text_buffer_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;

  // 13 bits covers every legal geometry (cols <= 128, rows <= 64).
  localparam int ADDR_W = 13;

  localparam logic [6:0] CHR_LF    = 7'h0A;
  localparam logic [6:0] CHR_CR    = 7'h0D;
  localparam logic [6:0] CHR_BS    = 7'h08;
  localparam logic [6:0] CHR_FF    = 7'h0C;
  localparam logic [6:0] CHR_SPACE = 7'h20;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_CLRROW = 2'd2;

  // Linear RAM address of a physical cell.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                  input logic [6:0] col,
                                                  input logic [6:0] cols);
    return ADDR_W'(row) * ADDR_W'(cols) + ADDR_W'(col);
  endfunction

  // (row + top) mod rows, valid for row, top < rows.
  function automatic logic [5:0] wrap_row(input logic [5:0] row,
                                          input logic [5:0] top,
                                          input logic [6:0] rows);
    logic [6:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= rows) begin
      sum = sum - rows;
    end else begin
      sum = sum;
    end
    return sum[5:0];
  endfunction

endpackage

// File: rtl/text_buffer_if.sv
// text_buffer_if: valid/ready character write port.
//   wr_valid  source -> sink  write request
//   wr_char   source -> sink  character or control code (`FONT_WIDTH bits)
//   wr_ready  sink -> source  sink accepts wr_char this cycle
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

interface text_buffer_if;
  logic                   wr_valid;
  logic [`FONT_WIDTH-1:0] wr_char;
  logic                   wr_ready;

  modport master (output wr_valid, output wr_char, input wr_ready);
  modport slave  (input wr_valid, input wr_char, output wr_ready);
endinterface

// File: rtl/text_ram.sv
// text_ram: simple dual-port cell memory, shaped for block-RAM inference.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data; a same-address write returns old data
module text_ram #(
  parameter int DEPTH = 4800,
  parameter int WIDTH = 8,
  parameter int AW    = 13
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_r;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port (read-before-write on collision).
  always_ff @(posedge clk) begin
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character-cell frame buffer feeding the font renderer.
//   px_clk      in   pixel clock
//   reset       in   synchronous active-high reset (starts a full clear)
//   pos_x/pos_y in   beam position
//   wr          slave write port (text_buffer_if)
//   character   out  cell code under pos_*_d (0 when off-screen)
//   pos_x_d/_y_d out beam position delayed one cycle
//   cursor_col/_row out hardware cursor
// Build option: TEXT_SCROLL_EN makes a row advance from the last row scroll
// the screen via a top-row offset; otherwise the cursor wraps to row 0.
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                   px_clk,
  input  logic                   reset,
  input  logic [9:0]             pos_x,
  input  logic [9:0]             pos_y,
  text_buffer_if.slave           wr,
  output logic [`FONT_WIDTH-1:0] character,
  output logic [9:0]             pos_x_d,
  output logic [9:0]             pos_y_d,
  output logic [6:0]             cursor_col,
  output logic [5:0]             cursor_row
);

  localparam int                FW          = `FONT_WIDTH;
  localparam logic [6:0]        COLS_W      = 7'(COLS);
  localparam logic [6:0]        ROWS_W      = 7'(ROWS);
  localparam logic [6:0]        COL_LAST    = 7'(COLS - 1);
  localparam logic [5:0]        ROW_LAST    = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST   = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROWCLR_LAST = ADDR_W'(COLS - 1);

  logic [1:0]        state_r, state_nxt_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
  logic [6:0]        col_r, col_nxt_s;
  logic [5:0]        row_r, row_nxt_s;
  logic              wr_ready_r;
  logic              adv_s;
  logic              we_s;
  logic [ADDR_W-1:0] wa_s;
  logic [FW-1:0]     wd_s;
  logic [5:0]        cur_phys_s;
`ifdef TEXT_SCROLL_EN
  logic [5:0]        top_r, top_nxt_s;
  logic [5:0]        clr_row_r, clr_row_nxt_s;
`endif

  logic [6:0]        rd_col_s, rd_row_s;
  logic              rd_in_range_s;
  logic [5:0]        rd_phys_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_valid_r;
  logic [9:0]        pos_x_d_r, pos_y_d_r;
  logic [FW-1:0]     ram_q_s;

  // Read-side address: beam cell mapped through the scroll offset.
  always_comb begin
    rd_col_s      = pos_x[9:3];
    rd_row_s      = pos_y[9:3];
    rd_in_range_s = (rd_col_s < COLS_W) && (rd_row_s < ROWS_W);
`ifdef TEXT_SCROLL_EN
    rd_phys_s  = wrap_row(rd_row_s[5:0], top_r, ROWS_W);
    cur_phys_s = wrap_row(row_r, top_r, ROWS_W);
`else
    rd_phys_s  = rd_row_s[5:0];
    cur_phys_s = row_r;
`endif
    if (rd_in_range_s) begin
      rd_addr_s = cell_addr(rd_phys_s, rd_col_s, COLS_W);
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Control FSM: code interpretation, clear sequencing and cursor update.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    adv_s       = 1'b0;
    we_s        = 1'b0;
    wa_s        = {ADDR_W{1'b0}};
    wd_s        = {FW{1'b0}};
`ifdef TEXT_SCROLL_EN
    top_nxt_s     = top_r;
    clr_row_nxt_s = clr_row_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (wr.wr_valid) begin
          if (wr.wr_char == FW'(CHR_LF)) begin
            col_nxt_s = 7'd0;
            adv_s     = 1'b1;
          end else if (wr.wr_char == FW'(CHR_CR)) begin
            col_nxt_s = 7'd0;
          end else if (wr.wr_char == FW'(CHR_BS)) begin
            if (col_r != 7'd0) begin
              col_nxt_s = col_r - 7'd1;
            end else begin
              col_nxt_s = col_r;
            end
          end else if (wr.wr_char == FW'(CHR_FF)) begin
            state_nxt_s = ST_CLEAR;
            cnt_nxt_s   = {ADDR_W{1'b0}};
          end else begin
            we_s = 1'b1;
            wa_s = cell_addr(cur_phys_s, col_r, COLS_W);
            wd_s = wr.wr_char;
            if (col_r == COL_LAST) begin
              col_nxt_s = 7'd0;
              adv_s     = 1'b1;
            end else begin
              col_nxt_s = col_r + 7'd1;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        we_s = 1'b1;
        wa_s = cnt_r;
        wd_s = FW'(CHR_SPACE);
        if (cnt_r == CELL_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {ADDR_W{1'b0}};
          col_nxt_s   = 7'd0;
          row_nxt_s   = 6'd0;
`ifdef TEXT_SCROLL_EN
          top_nxt_s   = 6'd0;
`endif
        end else begin
          cnt_nxt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef TEXT_SCROLL_EN
      ST_CLRROW: begin
        we_s = 1'b1;
        wa_s = cell_addr(clr_row_r, cnt_r[6:0], COLS_W);
        wd_s = FW'(CHR_SPACE);
        if (cnt_r == ROWCLR_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase

    // Row advance; from the last row either scroll (blank old top) or wrap.
    if (adv_s) begin
      if (row_r < ROW_LAST) begin
        row_nxt_s = row_r + 6'd1;
      end else begin
`ifdef TEXT_SCROLL_EN
        top_nxt_s     = wrap_row(top_r, 6'd1, ROWS_W);
        clr_row_nxt_s = top_r;
        state_nxt_s   = ST_CLRROW;
        cnt_nxt_s     = {ADDR_W{1'b0}};
`else
        row_nxt_s = 6'd0;
`endif
      end
    end else begin
      // cursor row already settled by the state logic above
    end
  end

  // Control state registers; reset restarts a full-screen clear.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      cnt_r      <= {ADDR_W{1'b0}};
      col_r      <= 7'd0;
      row_r      <= 6'd0;
      wr_ready_r <= 1'b0;
`ifdef TEXT_SCROLL_EN
      top_r      <= 6'd0;
      clr_row_r  <= 6'd0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      col_r      <= col_nxt_s;
      row_r      <= row_nxt_s;
      wr_ready_r <= (state_nxt_s == ST_IDLE);
`ifdef TEXT_SCROLL_EN
      top_r      <= top_nxt_s;
      clr_row_r  <= clr_row_nxt_s;
`endif
    end
  end

  // Read pipeline: delayed position and in-range flag aligned with RAM data.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      pos_x_d_r  <= 10'd0;
      pos_y_d_r  <= 10'd0;
      rd_valid_r <= 1'b0;
    end else begin
      pos_x_d_r  <= pos_x;
      pos_y_d_r  <= pos_y;
      rd_valid_r <= rd_in_range_s;
    end
  end

  text_ram #(
    .DEPTH (COLS * ROWS),
    .WIDTH (FW),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (px_clk),
    .we    (we_s & ~reset),
    .waddr (wa_s),
    .wdata (wd_s),
    .raddr (rd_addr_s),
    .rdata (ram_q_s)
  );

  // Off-screen cells (and the cycle after reset) read as code 0.
  assign character   = rd_valid_r ? ram_q_s : {FW{1'b0}};
  assign pos_x_d     = pos_x_d_r;
  assign pos_y_d     = pos_y_d_r;
  assign cursor_col  = col_r;
  assign cursor_row  = row_r;
  assign wr.wr_ready = wr_ready_r;

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: randomized self-checking bench for text_buffer.
// The reference model keeps the screen as rows of characters in display
// order; scrolling shifts the rows, clearing overwrites them all.
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module tb_text_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;
  localparam int FW    = `FONT_WIDTH;

  localparam logic [FW-1:0] C_LF = FW'(8'h0A);
  localparam logic [FW-1:0] C_CR = FW'(8'h0D);
  localparam logic [FW-1:0] C_BS = FW'(8'h08);
  localparam logic [FW-1:0] C_FF = FW'(8'h0C);

  logic          px_clk = 1'b0;
  logic          reset;
  logic [9:0]    pos_x, pos_y;
  logic [FW-1:0] character;
  logic [9:0]    pos_x_d, pos_y_d;
  logic [6:0]    cursor_col;
  logic [5:0]    cursor_row;

  text_buffer_if wif ();

  text_buffer dut (
    .px_clk     (px_clk),
    .reset      (reset),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .wr         (wif),
    .character  (character),
    .pos_x_d    (pos_x_d),
    .pos_y_d    (pos_y_d),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 px_clk = ~px_clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [FW-1:0] screen [ROWS][COLS];
  int            m_col = 0, m_row = 0, busy = 0;
  bit            pend_clr = 1'b0;
  bit            started  = 1'b0;
  logic [FW-1:0] e_char;
  logic [9:0]    e_px, e_py;
  bit            e_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_read(input logic [9:0] px, input logic [9:0] py);
    int c, r;
    c = int'(px[9:3]);
    r = int'(py[9:3]);
    if (c < COLS && r < ROWS) return screen[r][c];
    else return {FW{1'b0}};
  endfunction

  task automatic m_advance();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef TEXT_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) screen[r][c] = screen[r+1][c];
      for (int c = 0; c < COLS; c++) screen[ROWS-1][c] = FW'(8'h20);
      busy = COLS;
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic m_apply(input logic [FW-1:0] ch);
    if (ch == C_LF) begin
      m_col = 0;
      m_advance();
    end else if (ch == C_CR) begin
      m_col = 0;
    end else if (ch == C_BS) begin
      if (m_col > 0) m_col--;
    end else if (ch == C_FF) begin
      busy = CELLS;
      pend_clr = 1'b1;
    end else begin
      screen[m_row][m_col] = ch;
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_advance();
      end else begin
        m_col++;
      end
    end
  endtask

  // model: advance on every active edge using the inputs seen at that edge
  always @(posedge px_clk) begin
    if (reset === 1'b1) begin
      e_chk = 1'b1; e_char = {FW{1'b0}}; e_px = 10'd0; e_py = 10'd0;
      m_col = 0; m_row = 0; busy = CELLS; pend_clr = 1'b1;
    end else begin
      e_chk  = (busy == 0);
      e_char = model_read(pos_x, pos_y);
      e_px   = pos_x;
      e_py   = pos_y;
      if (busy > 0) begin
        busy--;
        if (busy == 0 && pend_clr) begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) screen[r][c] = FW'(8'h20);
          m_col = 0; m_row = 0; pend_clr = 1'b0;
        end
      end else if (wif.wr_valid === 1'b1) begin
        m_apply(wif.wr_char);
      end
    end
    started = 1'b1;
  end

  // compare process: every output, every cycle, away from the active edge
  always @(negedge px_clk) begin
    if (started) begin
      check("wr_ready",   32'(wif.wr_ready), 32'(busy == 0));
      check("cursor_col", 32'(cursor_col),   32'(m_col));
      check("cursor_row", 32'(cursor_row),   32'(m_row));
      check("pos_x_d",    32'(pos_x_d),      32'(e_px));
      check("pos_y_d",    32'(pos_y_d),      32'(e_py));
      if (e_chk) check("character", 32'(character), 32'(e_char));
    end
  end

  task automatic tick();
    @(negedge px_clk);
  endtask

  task automatic send(input logic [FW-1:0] c);
    int guard;
    guard = 0;
    wif.wr_valid = 1'b1;
    wif.wr_char  = c;
    while (wif.wr_ready !== 1'b1 && guard < 6000) begin
      tick();
      guard++;
    end
    if (guard >= 6000) begin
      total++; bad++;
      $display("FAIL send_timeout: wr_ready still %b after %0d cycles", wif.wr_ready, guard);
    end
    tick();
    wif.wr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (wif.wr_ready !== 1'b1 && n < 10000) begin
      tick();
      n++;
    end
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        pos_x = 10'(c * 8 + $urandom_range(0, 7));
        pos_y = 10'(r * 8 + $urandom_range(0, 7));
        tick();
      end
  endtask

  initial begin
    int n;
    int sel;
    reset = 1'b1; wif.wr_valid = 1'b0; wif.wr_char = {FW{1'b0}};
    pos_x = 10'd0; pos_y = 10'd0;
    tick();
    reset = 1'b0;

    // reset: full clear, then blank screen and home cursor
    wait_ready(n);
    check("reset_clear_cycles", 32'(n), 32'd4800);
    check("reset_cursor_col", 32'(cursor_col), 32'd0);
    check("reset_cursor_row", 32'(cursor_row), 32'd0);
    pos_x = 10'd0; pos_y = 10'd0; tick();
    check("reset_cell0_space", 32'(character), 32'h20);
    sweep();

    // "AB" then read back cell (1,0), then off the right edge
    send(FW'(8'h41)); send(FW'(8'h42));
    pos_x = 10'd8; pos_y = 10'd0; tick();
    check("read_B", 32'(character), 32'h42);
    check("read_B_pos_x_d", 32'(pos_x_d), 32'd8);
    check("read_B_pos_y_d", 32'(pos_y_d), 32'd0);
    pos_x = 10'd640; tick();
    check("read_x640", 32'(character), 32'd0);

    // full line wraps to the next row; BS/CR at column 0 do nothing
    send(C_CR);
    repeat (80) send(FW'(8'h41));
    check("line_wrap_col", 32'(cursor_col), 32'd0);
    check("line_wrap_row", 32'(cursor_row), 32'd1);
    send(C_BS);
    check("bs_col0_col", 32'(cursor_col), 32'd0);
    check("bs_col0_row", 32'(cursor_row), 32'd1);
    send(C_CR);
    check("cr_col0_col", 32'(cursor_col), 32'd0);
    check("cr_col0_row", 32'(cursor_row), 32'd1);

    // random traffic with random beam positions
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 15));
      pos_x = 10'($urandom_range(0, 700));
      pos_y = 10'($urandom_range(0, 520));
      wif.wr_valid = ($urandom_range(0, 3) != 0);
      if (i == 2900) begin
        wif.wr_valid = 1'b1; wif.wr_char = C_FF;
      end else if (sel < 2) wif.wr_char = C_LF;
      else if (sel == 2) wif.wr_char = C_CR;
      else if (sel == 3) wif.wr_char = C_BS;
      else wif.wr_char = FW'($urandom_range(33, 126));
      tick();
    end
    wif.wr_valid = 1'b0;
    wait_ready(n);
    sweep();

    // form feed mid-stream: full clear
    send(FW'(8'h5A));
    send(C_FF);
    wait_ready(n);
    check("ff_clear_cycles", 32'(n), 32'd4800);
    check("ff_cursor_col", 32'(cursor_col), 32'd0);
    check("ff_cursor_row", 32'(cursor_row), 32'd0);

    // fill every row with a tag letter, then advance past the last row
    for (int r = 0; r < ROWS; r++) begin
      send(FW'(8'h41 + r % 26));
      if (r < ROWS - 1) send(C_LF);
    end
    check("fill_cursor_col", 32'(cursor_col), 32'd1);
    check("fill_cursor_row", 32'(cursor_row), 32'd59);
    send(C_LF);
`ifdef TEXT_SCROLL_EN
    wait_ready(n);
    check("scroll_busy_cycles", 32'(n), 32'd80);
    check("scroll_cursor_col", 32'(cursor_col), 32'd0);
    check("scroll_cursor_row", 32'(cursor_row), 32'd59);
    pos_x = 10'd0; pos_y = 10'd0; tick();
    check("scroll_row0_is_old_row1", 32'(character), 32'h42);
    pos_y = 10'd472; tick();
    check("scroll_row59_blank", 32'(character), 32'h20);
`else
    check("wrap_ready_high", 32'(wif.wr_ready), 32'd1);
    check("wrap_cursor_col", 32'(cursor_col), 32'd0);
    check("wrap_cursor_row", 32'(cursor_row), 32'd0);
    pos_x = 10'd0; pos_y = 10'd0; tick();
    check("wrap_row0_kept", 32'(character), 32'h41);
`endif
    sweep();

    // reset 100 cycles into a clear restarts the full clear
    send(C_FF);
    repeat (100) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready(n);
    check("reset_mid_clear_cycles", 32'(n), 32'd4800);
    check("reset_mid_clear_col", 32'(cursor_col), 32'd0);
    check("reset_mid_clear_row", 32'(cursor_row), 32'd0);
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
